ram_arbiter: RTL
================

# ram_arbiter

Two-requester arbiter and sequencer in front of the processor's single-port synchronous RAM, with one port for instruction fetch and one for load/store. It accepts at most one request per transaction, drives the RAM's write-enable, address and write-data, and returns the read word (or a write acknowledge) to the requester that issued it. It sits between the fetch/memory stages of the core and the RAM instance. The RAM reads and writes on the same clock edge and is mutually exclusive: no read data is produced on a write cycle.

## Interface
- WORDSIZE, 32, data word width
- WORDS, 256, RAM depth; AW = $clog2(WORDS)

- Clock  in  1  single clock, all state on rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- Befehl_Gueltig  in  1  fetch request valid (read only)
- Befehl_Adresse  in  AW  fetch word address
- Befehl_Bereit  out  1  fetch request accepted this cycle
- Befehl_Daten  out  WORDSIZE  fetched word; 0 when Befehl_DatenGueltig=0
- Befehl_DatenGueltig  out  1  one-cycle fetch response pulse
- Speicher_Gueltig  in  1  load/store request valid
- Speicher_Schreiben  in  1  1=store, 0=load
- Speicher_Adresse  in  AW  load/store word address
- Speicher_DatenRein  in  WORDSIZE  store data
- Speicher_Bereit  out  1  load/store request accepted this cycle
- Speicher_DatenRaus  out  WORDSIZE  load data; 0 otherwise (also 0 on store ack)
- Speicher_DatenGueltig  out  1  one-cycle load data / store acknowledge pulse
- Ram_SchreibenAn  out  1  to RAM write enable
- Ram_Adresse  out  AW  to RAM address
- Ram_DatenRein  out  WORDSIZE  to RAM write data
- Ram_DatenRaus  in  WORDSIZE  from RAM read data

## Operation
- States:
  - LEERLAUF (idle)
  - BEFEHL_LESEN (fetch read in flight)
  - SPEICHER_LESEN (load read in flight)
  - SPEICHER_SCHREIBEN (store acknowledge)
- Arbitration is evaluated only in LEERLAUF:
  - Only one Gueltig high: grant it.
  - Both high: grant the port not served last (round-robin bit Letzter).
  - After reset, Letzter=Befehl, so load/store wins the first tie.
- In LEERLAUF, grant drives Bereit=1 combinationally.
  - RAM-side outputs also come combinationally from the granted request.
  - Ram_SchreibenAn=1 only for a granted store.
  - Ram_DatenRein is the store data, else 0.
- No grant: Ram_SchreibenAn=0, Ram_Adresse=0, Ram_DatenRein=0 (the RAM then performs a harmless read of address 0).
- Acceptance at posedge with Gueltig&Bereit:
  - Moves to the matching state.
  - Updates Letzter.
- Every non-idle state lasts exactly one cycle, then returns to LEERLAUF.
  - Bereit=0 for both ports.
  - Ram_SchreibenAn=0.
- BEFEHL_LESEN: Befehl_DatenGueltig=1 and Befehl_Daten=Ram_DatenRaus (combinational pass-through).
- SPEICHER_LESEN: Speicher_DatenGueltig=1 and Speicher_DatenRaus=Ram_DatenRaus.
- SPEICHER_SCHREIBEN: Speicher_DatenGueltig=1 and Speicher_DatenRaus=0.
- Responses have no backpressure; requesters must consume the pulse.
- A requester may drop Gueltig before acceptance. Nothing is committed and Letzter is unchanged.

## Timing
- Reset (Reset_n=0, asynchronous):
  - State=LEERLAUF, Letzter=Befehl.
  - All outputs 0, including Bereit.
- Release is synchronous to the next edge.
- Accept edge T:
  - Read: data valid during cycle T+1 (after edge T), response pulse in the same cycle.
  - Write: RAM updated at edge T; ack pulse during cycle T+1.
- Throughput: one transaction per 2 cycles. Back-to-back accept is possible at T+2.
- Continuous contention alternates strictly: S, B, S, B…
- Reset asserted mid-transaction: the in-flight response is dropped (no pulse). A store already clocked at edge T remains in RAM.
- Read of a just-written address: the next transaction returns the new data.

## Structure
- Package ram_arbiter_pkg: state enum (LEERLAUF, BEFEHL_LESEN, SPEICHER_LESEN, SPEICHER_SCHREIBEN) and port-select constants (PORT_BEFEHL=0, PORT_SPEICHER=1).
- One sub-module, ram_arbiter_wahl: 2-way round-robin pick.
  - Inputs: two valids, Letzter, enable.
  - Output: one-hot grant.
- FSM, output muxing and the RAM interface live in the top module.

## Test plan
- Reset with Gueltig high on both ports -> all outputs 0; after release, first tie grants Speicher.
- Store 0x8020FFFF to addr 5, then load addr 5 -> Ram_SchreibenAn pulses once at accept, ack pulse in T+1 with Speicher_DatenRaus=0, load returns 0x8020FFFF in its T+1.
- Both ports valid for 8 cycles (fetch addrs 0,1; store/load addrs 10,11) -> grants alternate S,B,S,B, one accept every 2 cycles, each response on its own port only.
- Only fetch valid, addresses 0..3 -> accepts at cycles 0,2,4,6, Befehl_Daten matches the preloaded words, Speicher_DatenGueltig stays 0.
- Reset_n pulsed low during BEFEHL_LESEN -> no Befehl_DatenGueltig pulse, state LEERLAUF, Letzter=Befehl.
- Speicher_Gueltig raised then dropped in the same cycle as a fetch win -> no store to RAM, Letzter flips only for the fetch.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the instruction-fetch / load-store RAM arbiter.
// Sequencer states and the port-select constants used to index grants.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        LEERLAUF           = 2'd0,
        BEFEHL_LESEN       = 2'd1,
        SPEICHER_LESEN     = 2'd2,
        SPEICHER_SCHREIBEN = 2'd3
    } zustand_t;

    localparam logic PORT_BEFEHL   = 1'b0;
    localparam logic PORT_SPEICHER = 1'b1;

endpackage

// File: rtl/ram_arbiter_wahl.sv
// Two-way round-robin pick between fetch and load/store requests.
// Grant is one-hot, indexed by PORT_BEFEHL / PORT_SPEICHER.
module ram_arbiter_wahl
    import ram_arbiter_pkg::*;
(
    input  logic       gueltig_befehl,
    input  logic       gueltig_speicher,
    input  logic       letzter,
    input  logic       enable,
    output logic [1:0] grant
);

    always_comb begin
        grant = '0;
        if (enable) begin
            if (gueltig_befehl && gueltig_speicher) begin
                // on a tie the port that was not served last wins
                if (letzter == PORT_BEFEHL) grant[PORT_SPEICHER] = 1'b1;
                else                        grant[PORT_BEFEHL]   = 1'b1;
            end else if (gueltig_befehl) begin
                grant[PORT_BEFEHL] = 1'b1;
            end else if (gueltig_speicher) begin
                grant[PORT_SPEICHER] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Arbiter/sequencer in front of the single-port synchronous RAM shared by
// instruction fetch and load/store; one transaction every two cycles.
//
// state              | meaning
// -------------------+------------------------------------------------
// LEERLAUF           | idle, arbitrating, RAM driven by granted request
// BEFEHL_LESEN       | fetch read data on Ram_DatenRaus, pulse to fetch
// SPEICHER_LESEN     | load read data on Ram_DatenRaus, pulse to ld/st
// SPEICHER_SCHREIBEN | store written last edge, ack pulse to ld/st
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int WORDSIZE = 32,
    parameter  int WORDS    = 256,
    localparam int AW       = $clog2(WORDS)
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                Befehl_Gueltig,
    input  logic [AW-1:0]       Befehl_Adresse,
    output logic                Befehl_Bereit,
    output logic [WORDSIZE-1:0] Befehl_Daten,
    output logic                Befehl_DatenGueltig,
    input  logic                Speicher_Gueltig,
    input  logic                Speicher_Schreiben,
    input  logic [AW-1:0]       Speicher_Adresse,
    input  logic [WORDSIZE-1:0] Speicher_DatenRein,
    output logic                Speicher_Bereit,
    output logic [WORDSIZE-1:0] Speicher_DatenRaus,
    output logic                Speicher_DatenGueltig,
    output logic                Ram_SchreibenAn,
    output logic [AW-1:0]       Ram_Adresse,
    output logic [WORDSIZE-1:0] Ram_DatenRein,
    input  logic [WORDSIZE-1:0] Ram_DatenRaus
);

    zustand_t   zustand, zustand_next;
    logic       letzter, letzter_next;
    logic       wahl_enable;
    logic [1:0] grant;

    // Gating with Reset_n keeps the combinational grant path quiet while in reset
    assign wahl_enable = (zustand == LEERLAUF) && Reset_n;

    ram_arbiter_wahl u_wahl (
        .gueltig_befehl   (Befehl_Gueltig),
        .gueltig_speicher (Speicher_Gueltig),
        .letzter          (letzter),
        .enable           (wahl_enable),
        .grant            (grant)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            zustand <= LEERLAUF;
            letzter <= PORT_BEFEHL;
        end else begin
            zustand <= zustand_next;
            letzter <= letzter_next;
        end
    end

    always_comb begin
        zustand_next          = LEERLAUF;
        letzter_next          = letzter;
        Befehl_Bereit         = 1'b0;
        Befehl_Daten          = '0;
        Befehl_DatenGueltig   = 1'b0;
        Speicher_Bereit       = 1'b0;
        Speicher_DatenRaus    = '0;
        Speicher_DatenGueltig = 1'b0;
        Ram_SchreibenAn       = 1'b0;
        Ram_Adresse           = '0;
        Ram_DatenRein         = '0;

        case (zustand)
            LEERLAUF: begin
                if (grant[PORT_SPEICHER]) begin
                    Speicher_Bereit = 1'b1;
                    Ram_Adresse     = Speicher_Adresse;
                    Ram_SchreibenAn = Speicher_Schreiben;
                    Ram_DatenRein   = Speicher_Schreiben ? Speicher_DatenRein : '0;
                    letzter_next    = PORT_SPEICHER;
                    zustand_next    = Speicher_Schreiben ? SPEICHER_SCHREIBEN : SPEICHER_LESEN;
                end else if (grant[PORT_BEFEHL]) begin
                    Befehl_Bereit = 1'b1;
                    Ram_Adresse   = Befehl_Adresse;
                    letzter_next  = PORT_BEFEHL;
                    zustand_next  = BEFEHL_LESEN;
                end
            end
            BEFEHL_LESEN: begin
                Befehl_DatenGueltig = 1'b1;
                Befehl_Daten        = Ram_DatenRaus;
            end
            SPEICHER_LESEN: begin
                Speicher_DatenGueltig = 1'b1;
                Speicher_DatenRaus    = Ram_DatenRaus;
            end
            SPEICHER_SCHREIBEN: begin
                Speicher_DatenGueltig = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
